// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a 4-digit 7-segment display.
//
// Each digit slot is TICK_DIV cycles long. The first BLANK_CYC cycles of a slot
// are dark to suppress ghosting, and the rest drive the digit. Digit data is held
// in a shadow register that only changes at a frame start or while idle, so a
// frame never shows a half-written value.
//
// Optional build macro: SEG_SCAN_LZ_BLANK_EN enables leading-zero suppression.
//
// All outputs are registered. The next-state values (state, cnt, sct) are formed
// combinationally, and the output registers load the values that belong to the
// next state. Registered outputs therefore stay cycle-aligned with the state.
//
// Load handshake: load_i sets a sticky pending flag. A capture takes place at the
// clock edge that enters a frame start, or at any edge that leaves an IDLE cycle,
// when pending or load_i is set. load_i sampled at that edge is served
// immediately. load_ack_o is high in the cycle after the capturing edge. For a
// frame-start capture, that is the same cycle as frame_o.
module seg_scan_ctrl #(
    parameter int TICK_DIV  = 100000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic [15:0] digits_i,
    input  logic [3:0]  dp_i,
    input  logic        load_i,
    output logic        load_ack_o,
    output logic [1:0]  sct_o,
    output logic [3:0]  en_o,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic        frame_o
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_sct;
    logic [15:0]      r_shadow;
    logic [3:0]       r_shadow_dp;
    logic             r_pending;
    logic             r_ack;
    logic             r_frame;
    logic [3:0]       r_en;
    logic [6:0]       r_seg;
    logic             r_dp;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       w_sct_nxt;
    logic             w_frame_nxt;
    logic             w_cap;
    logic [3:0]       w_nib;
    logic             w_lz;
    logic [6:0]       w_seg;

    // Hex to active-high segment pattern, bit 0 = a ... bit 6 = g
    function automatic logic [6:0] font(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Next-state sequencing: enable_i low forces IDLE from any state
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sct_nxt   = r_sct;
        if (!enable_i) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_sct_nxt   = 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_BLANK;
                    w_cnt_nxt   = '0;
                    w_sct_nxt   = 2'd0;
                end
                ST_BLANK: begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == BLANK_LAST) begin
                        w_state_nxt = ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (r_cnt == SLOT_LAST) begin
                        w_cnt_nxt   = '0;
                        w_sct_nxt   = r_sct + 2'd1;
                        w_state_nxt = ST_BLANK;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_sct_nxt   = 2'd0;
                end
            endcase
        end
    end

    // Frame start detection, capture decision and segment pattern for the next slot
    always_comb begin
        w_frame_nxt = (w_state_nxt == ST_BLANK) && (w_cnt_nxt == '0) && (w_sct_nxt == 2'd0);
        w_cap       = ((r_state == ST_IDLE) || w_frame_nxt) && (r_pending || load_i);
        case (w_sct_nxt)
            2'd0:    w_nib = r_shadow[15:12];
            2'd1:    w_nib = r_shadow[11:8];
            2'd2:    w_nib = r_shadow[7:4];
            default: w_nib = r_shadow[3:0];
        endcase
`ifdef SEG_SCAN_LZ_BLANK_EN
        case (w_sct_nxt)
            2'd0:    w_lz = (r_shadow[15:12] == 4'h0);
            2'd1:    w_lz = (r_shadow[15:8] == 8'h00);
            2'd2:    w_lz = (r_shadow[15:4] == 12'h000);
            default: w_lz = 1'b0;
        endcase
`else
        w_lz = 1'b0;
`endif
        w_seg = w_lz ? 7'h00 : font(w_nib);
    end

    // State, counters, shadow, pending flag and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_sct       <= 2'd0;
            r_shadow    <= 16'h0000;
            r_shadow_dp <= 4'h0;
            r_pending   <= 1'b0;
            r_ack       <= 1'b0;
            r_frame     <= 1'b0;
            r_en        <= 4'h0;
            r_seg       <= 7'h00;
            r_dp        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sct   <= w_sct_nxt;
            r_frame <= w_frame_nxt;
            r_ack   <= w_cap;
            if (w_cap) begin
                r_shadow    <= digits_i;
                r_shadow_dp <= dp_i;
                r_pending   <= 1'b0;
            end else begin
                r_pending   <= r_pending | load_i;
            end
            if (w_state_nxt == ST_DRIVE) begin
                r_en  <= 4'b1000 >> w_sct_nxt;
                r_seg <= w_seg;
                r_dp  <= r_shadow_dp[2'd3 - w_sct_nxt];
            end else begin
                r_en  <= 4'h0;
                r_seg <= 7'h00;
                r_dp  <= 1'b0;
            end
        end
    end

    assign load_ack_o = r_ack;
    assign sct_o      = r_sct;
    assign en_o       = r_en;
    assign seg_o      = r_seg;
    assign dp_o       = r_dp;
    assign frame_o    = r_frame;

endmodule
